if_fetch_unit: RTL and testbench

//  Instruction-fetch front end. Produces the PC/Instruction pair that the IF/ID

---
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack handshake with a
// multicycle instruction memory, buffers a word across freezes and drains redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        if_valid,
  output logic        flush,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buffer;
  logic [31:0] r_redirect;
  logic [31:0] r_count;

  logic [31:0] w_target;
  logic [31:0] w_pcNext;
  logic        w_fetchDeliver;
  logic        w_holdDeliver;

  // Redirect targets are always word aligned; the low two bits are discarded.
  assign w_target       = branch_addr & ~32'h0000_0003;
  assign w_pcNext       = r_pc + 32'd4;
  assign w_fetchDeliver = (r_state == FETCH) & imem_ack & ~branch_taken & ~freeze;
  assign w_holdDeliver  = (r_state == HOLD) & ~branch_taken & ~freeze;

  // Delivery is combinational so a zero-wait memory sustains one instruction per cycle.
  always_comb begin
    imem_req    = ~rst & ((r_state == FETCH) | (r_state == DRAIN));
    imem_addr   = r_pc;
    flush       = branch_taken & ~rst;
    if_valid    = ~rst & (w_fetchDeliver | w_holdDeliver);
    PC          = 32'd0;
    Instruction = 32'd0;
    if (if_valid) begin
      PC          = w_pcNext;
      Instruction = (r_state == HOLD) ? r_buffer : imem_rdata;
    end
    instr_count = r_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_buffer   <= 32'd0;
      r_redirect <= 32'd0;
      r_count    <= 32'd0;
    end else begin
      if (if_valid) begin
        r_count <= r_count + 32'd1;
      end
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            if (branch_taken) begin
              r_pc <= w_target;
            end else if (!freeze) begin
              r_pc <= w_pcNext;
            end else begin
              r_buffer <= imem_rdata;
              r_state  <= HOLD;
            end
          end else if (branch_taken) begin
            // The request in flight must complete before the new address goes out.
            r_redirect <= w_target;
            r_state    <= DRAIN;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (!freeze) begin
            r_pc    <= w_pcNext;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            r_pc    <= branch_taken ? w_target : r_redirect;
            r_state <= FETCH;
          end else if (branch_taken) begin
            r_redirect <= w_target;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a default-reset instance for the main scenarios
// and a second instance with RESET_PC at the top of the address space for wrap.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] pcOut;
  logic [31:0] instrOut;
  logic        ifValid;
  logic        flushOut;
  logic [31:0] instrCount;

  logic        rst2;
  logic        imemAck2;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic [31:0] pcOut2;
  logic [31:0] instrOut2;
  logic        ifValid2;
  logic        flushOut2;
  logic [31:0] instrCount2;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branchTaken),
    .branch_addr(branchAddr), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ack(imemAck), .imem_rdata(imemRdata), .PC(pcOut),
    .Instruction(instrOut), .if_valid(ifValid), .flush(flushOut),
    .instr_count(instrCount)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst2), .freeze(freeze), .branch_taken(branchTaken),
    .branch_addr(branchAddr), .imem_req(imemReq2), .imem_addr(imemAddr2),
    .imem_ack(imemAck2), .imem_rdata(imemRdata), .PC(pcOut2),
    .Instruction(instrOut2), .if_valid(ifValid2), .flush(flushOut2),
    .instr_count(instrCount2)
  );

  // Inputs change on the falling edge; outputs are checked 1 ns later.
  task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rdata,
                               input logic frz, input logic br, input logic [31:0] baddr);
    @(negedge clk);
    rst         = r;
    imemAck     = ack;
    imemRdata   = rdata;
    freeze      = frz;
    branchTaken = br;
    branchAddr  = baddr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst2     = 1'b1;
    imemAck2 = 1'b0;

    // Reset: nothing requested or delivered, and a branch cannot flush.
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h40);
    checkOutput("rst_req",   {31'd0, imemReq},  32'd0);
    checkOutput("rst_valid", {31'd0, ifValid},  32'd0);
    checkOutput("rst_flush", {31'd0, flushOut}, 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("rst_count", instrCount, 32'd0);
    checkOutput("rst_pc",    pcOut,      32'd0);

    // T1: zero-wait memory.
    applyStimulus(0, 1, 32'h1111_1111, 0, 0, 32'h0);
    checkOutput("t1_addr0",  imemAddr, 32'h0);
    checkOutput("t1_req0",   {31'd0, imemReq}, 32'd1);
    checkOutput("t1_valid0", {31'd0, ifValid}, 32'd1);
    checkOutput("t1_pc0",    pcOut,    32'h4);
    checkOutput("t1_ins0",   instrOut, 32'h1111_1111);
    applyStimulus(0, 1, 32'h2222_2222, 0, 0, 32'h0);
    checkOutput("t1_addr1",  imemAddr, 32'h4);
    checkOutput("t1_pc1",    pcOut,    32'h8);
    checkOutput("t1_ins1",   instrOut, 32'h2222_2222);
    applyStimulus(0, 1, 32'h3333_3333, 0, 0, 32'h0);
    checkOutput("t1_addr2",  imemAddr, 32'h8);
    checkOutput("t1_pc2",    pcOut,    32'hC);

    // T2: three-cycle latency at address 0xC.
    applyStimulus(0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
    checkOutput("t1_count",  instrCount, 32'd3);
    checkOutput("t2_addrw0", imemAddr,   32'hC);
    checkOutput("t2_validw", {31'd0, ifValid}, 32'd0);
    checkOutput("t2_pcw",    pcOut,      32'd0);
    applyStimulus(0, 0, 32'hDEAD_BEEF, 1, 0, 32'h0);
    checkOutput("t2_addrw1", imemAddr,   32'hC);
    checkOutput("t2_reqw1",  {31'd0, imemReq}, 32'd1);
    applyStimulus(0, 1, 32'h4444_4444, 0, 0, 32'h0);
    checkOutput("t2_addrack", imemAddr,  32'hC);
    checkOutput("t2_valid",  {31'd0, ifValid}, 32'd1);
    checkOutput("t2_pc",     pcOut,      32'h10);
    checkOutput("t2_ins",    instrOut,   32'h4444_4444);

    // T3: freeze on the ack cycle and two more cycles.
    applyStimulus(0, 1, 32'h5555_5555, 1, 0, 32'h0);
    checkOutput("t3_count",  instrCount, 32'd4);
    checkOutput("t3_addr",   imemAddr,   32'h10);
    checkOutput("t3_valid0", {31'd0, ifValid}, 32'd0);
    checkOutput("t3_ins0",   instrOut,   32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t3_req1",   {31'd0, imemReq}, 32'd0);
    checkOutput("t3_valid1", {31'd0, ifValid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t3_req2",   {31'd0, imemReq}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t3_valid3", {31'd0, ifValid}, 32'd1);
    checkOutput("t3_ins3",   instrOut,   32'h5555_5555);
    checkOutput("t3_pc3",    pcOut,      32'h14);
    checkOutput("t3_req3",   {31'd0, imemReq}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t3_nextaddr", imemAddr, 32'h14);
    checkOutput("t3_count5", instrCount, 32'd5);

    // T4: branch during a wait cycle drains the in-flight fetch.
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h40);
    checkOutput("t4_flush",  {31'd0, flushOut}, 32'd1);
    checkOutput("t4_addrb",  imemAddr,   32'h14);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t4_flush0", {31'd0, flushOut}, 32'd0);
    checkOutput("t4_addrd",  imemAddr,   32'h14);
    checkOutput("t4_reqd",   {31'd0, imemReq}, 32'd1);
    applyStimulus(0, 1, 32'h6666_6666, 0, 0, 32'h0);
    checkOutput("t4_validack", {31'd0, ifValid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t4_target", imemAddr,   32'h40);
    checkOutput("t4_count",  instrCount, 32'd5);

    // T5: branch on an ack cycle, then branch+freeze in HOLD with a misaligned target.
    applyStimulus(0, 1, 32'h7777_7777, 0, 1, 32'h100);
    checkOutput("t5_validbr", {31'd0, ifValid}, 32'd0);
    checkOutput("t5_flushbr", {31'd0, flushOut}, 32'd1);
    applyStimulus(0, 1, 32'h8888_8888, 1, 0, 32'h0);
    checkOutput("t5_addr100", imemAddr, 32'h100);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h83);
    checkOutput("t5_holdreq", {31'd0, imemReq}, 32'd0);
    checkOutput("t5_holdval", {31'd0, ifValid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t5_addr80", imemAddr,   32'h80);
    checkOutput("t5_count",  instrCount, 32'd5);

    // A second branch while draining overrides the first; a branch on the drain ack wins.
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h200);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h300);
    checkOutput("drn_addr", imemAddr, 32'h80);
    applyStimulus(0, 1, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h400);
    checkOutput("drn_over", imemAddr, 32'h300);
    applyStimulus(0, 1, 32'h0, 0, 1, 32'h500);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("drn_ackbr", imemAddr, 32'h500);

    // Reset mid-wait abandons the request and clears the count.
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("mrst_req", {31'd0, imemReq}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("mrst_addr",  imemAddr,   32'h0);
    checkOutput("mrst_count", instrCount, 32'd0);

    // T6: PC wrap on the top-of-memory instance.
    @(negedge clk);
    rst2 = 1'b0;
    imemAck2 = 1'b1;
    imemRdata = 32'h9999_9999;
    #1;
    checkOutput("t6_addr",  imemAddr2, 32'hFFFF_FFFC);
    checkOutput("t6_valid", {31'd0, ifValid2}, 32'd1);
    checkOutput("t6_pc",    pcOut2,    32'h0);
    checkOutput("t6_ins",   instrOut2, 32'h9999_9999);
    @(negedge clk);
    imemAck2 = 1'b0;
    #1;
    checkOutput("t6_next",  imemAddr2,   32'h0);
    checkOutput("t6_count", instrCount2, 32'd1);
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    checkOutput("t6_rstreq", {31'd0, imemReq2}, 32'd0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    checkOutput("t6_rstaddr",  imemAddr2,   32'hFFFF_FFFC);
    checkOutput("t6_rstcount", instrCount2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
